dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder side of the CPU data-memory interface: a word-addressed data RAM that
//  accepts one request at a time from the CPU (or a bus master), inserts a
//  programmable number of wait states, then completes with a one-cycle ready pulse.
//  It replaces the zero-latency data memory when modelling slow memory for the
//  multi-cycle CPU. It also keeps saturating read/write access counters for debug.
// PARAMETERS
//  AW       5    address width; memory depth = 2**AW words of 32 bits
//  LATENCY  2    wait-state cycles inserted between request accept and response (0..15)
//  CNT_W    16   width of the read/write access counters
// PORTS
//  clk      in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  req      in   1      request strobe; sampled only in IDLE
//  we       in   1      1 = write, 0 = read; captured with req
//  addr     in   AW     word address; captured with req
//  datain   in   32     write data; captured with req
//  ready    out  1      one-cycle pulse: access complete
//  dataout  out  32     read data; valid when ready=1 on a read, then held
//  busy     out  1      1 whenever state != IDLE
//  rd_cnt   out  CNT_W  completed reads, saturating
//  wr_cnt   out  CNT_W  completed writes, saturating
// BEHAVIOUR
//  - Reset (synchronous): state=IDLE; ready=0, busy=0, dataout=0, rd_cnt=0, wr_cnt=0,
//    wait counter=0, every memory word cleared to 0. Reset wins over any request and
//    aborts an access mid-flight: a pending write is discarded, no ready pulse.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: req=1 -> latch we/addr/datain, load wait counter with LATENCY;
//          go WAIT if LATENCY>0, else RESP. req=0 -> stay.
//    WAIT: counter decrements each cycle; when counter reaches 1 -> RESP.
//    RESP: commit access, ready=1 for this cycle only, then IDLE unconditionally.
//  - Latency: req accepted in cycle N -> ready=1 in cycle N+LATENCY+1.
//    LATENCY=0 -> ready the cycle after req. Max throughput: one access per LATENCY+2 cycles.
//  - Write: mem[addr_latched] <= datain_latched at the RESP clock edge; dataout unchanged.
//  - Read: dataout <= mem[addr_latched] registered on entry to RESP so it is valid while
//    ready=1; dataout holds until the next completed read or reset.
//  - Only latched values are used: changes on we/addr/datain/req while busy=1 are ignored.
//    req held high through RESP is not re-accepted until the IDLE cycle that follows.
//  - Read of a word written by the immediately preceding access returns the new data.
//  - Counters: increment on the RESP cycle (rd_cnt on read, wr_cnt on write); hold at
//    2**CNT_W-1, no wrap.
//  - Address uses all AW bits; no out-of-range case exists.
// TESTING
//  1 Reset then read addr 5 (LATENCY=2): req@N -> ready=1 only @N+3, dataout=0,
//    busy=1 N+1..N+3, rd_cnt=1.
//  2 Write 0xDEADBEEF @3 then read @3 back-to-back -> second ready shows
//    dataout=0xDEADBEEF; wr_cnt=1, rd_cnt=1; dataout unchanged during write ready.
//  3 Change addr/datain/we and pulse req while busy -> ignored; result matches latched
//    request, exactly one ready per accepted req.
//  4 LATENCY=0 build: req held high continuously -> ready every 2nd cycle; write 0x1..0x4
//    to addr 0..3, read back 0x1..0x4.
//  5 Write 0x12345678 @7, assert reset during WAIT -> no ready; read @7 returns 0x0.
//  6 CNT_W=2: five reads -> rd_cnt sequence 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a CPU (master) and the wait-state data memory (slave).
// Carries the single-outstanding request, the ready pulse and the debug access counters.
interface dmem_responder_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic             req;
    logic             we;
    logic [AW-1:0]    addr;
    logic [31:0]      datain;
    logic             ready;
    logic [31:0]      dataout;
    logic             busy;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    modport master (
        output req, we, addr, datain,
        input  ready, dataout, busy, rd_cnt, wr_cnt
    );

    modport slave (
        input  req, we, addr, datain,
        output ready, dataout, busy, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM that accepts one request at a time, inserts LATENCY wait
// states and completes with a one-cycle ready pulse; keeps saturating access counters.
module dmem_responder #(
    parameter int AW      = 5,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic reset,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int DEPTH = 1 << AW;
    localparam logic [3:0] LAT = 4'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             we_l;
    logic [AW-1:0]    addr_l;
    logic [31:0]      data_l;
    logic [31:0]      mem [DEPTH];
    logic             ready_r;
    logic             busy_r;
    logic [31:0]      dataout_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [CNT_W-1:0] wr_cnt_r;

    // Read data is fetched on the edge entering RESP so it is valid alongside ready;
    // writes and counter updates happen on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            we_l      <= 1'b0;
            addr_l    <= '0;
            data_l    <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            dataout_r <= '0;
            rd_cnt_r  <= '0;
            wr_cnt_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_l     <= bus.we;
                        addr_l   <= bus.addr;
                        data_l   <= bus.datain;
                        wait_cnt <= LAT;
                        busy_r   <= 1'b1;
                        if (LATENCY == 0) begin
                            state   <= RESP;
                            ready_r <= 1'b1;
                            if (!bus.we) begin
                                dataout_r <= mem[bus.addr];
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state   <= RESP;
                        ready_r <= 1'b1;
                        if (!we_l) begin
                            dataout_r <= mem[addr_l];
                        end
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    if (we_l) begin
                        mem[addr_l] <= data_l;
                        if (wr_cnt_r != CNT_MAX) begin
                            wr_cnt_r <= wr_cnt_r + 1'b1;
                        end
                    end else if (rd_cnt_r != CNT_MAX) begin
                        rd_cnt_r <= rd_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.busy    = busy_r;
    assign bus.dataout = dataout_r;
    assign bus.rd_cnt  = rd_cnt_r;
    assign bus.wr_cnt  = wr_cnt_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three builds (LATENCY=2, LATENCY=0, CNT_W=2) checked
// against a behavioural memory model with expected responses queued per request.
module tb_dmem_responder;
    typedef struct {
        logic [31:0] data;
        logic        is_read;
    } exp_t;

    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    exp_t        sb_a[$];
    exp_t        sb_z[$];
    exp_t        sb_c[$];
    logic [31:0] model_a [32];
    logic [31:0] model_z [32];
    logic [31:0] last_read_a;
    logic [31:0] last_read_z;
    int          rd_exp_a;
    int          wr_exp_a;
    int          cnt_exp_c;
    int          cycles;
    bit          seen;
    exp_t        e;
    exp_t        got;

    always #5 clk = ~clk;

    dmem_responder_if #(.AW(5), .CNT_W(16)) bus_a ();
    dmem_responder_if #(.AW(5), .CNT_W(16)) bus_z ();
    dmem_responder_if #(.AW(5), .CNT_W(2))  bus_c ();

    dmem_responder #(.AW(5), .LATENCY(LAT_A), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    dmem_responder #(.AW(5), .LATENCY(0), .CNT_W(16)) dut_z (
        .clk(clk), .reset(reset), .bus(bus_z.slave)
    );
    dmem_responder #(.AW(5), .LATENCY(2), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with dut_a idle; returns at the negedge of the idle cycle after ready.
    task automatic applyStimulus(input logic w, input logic [4:0] a, input logic [31:0] d, input bit disturb);
        exp_t ex;
        exp_t gx;
        int   n;
        bit   hit;
        bus_a.req    = 1'b1;
        bus_a.we     = w;
        bus_a.addr   = a;
        bus_a.datain = d;
        ex.is_read   = ~w;
        if (w) begin
            ex.data    = last_read_a;
            model_a[a] = d;
            wr_exp_a++;
        end else begin
            ex.data     = model_a[a];
            last_read_a = model_a[a];
            rd_exp_a++;
        end
        sb_a.push_back(ex);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 20) begin
            @(negedge clk);
            n++;
            if (bus_a.ready) begin
                hit = 1'b1;
            end else begin
                checkOutput("busy_while_waiting", 32'(bus_a.busy), 32'd1);
                bus_a.req = disturb ? 1'($urandom) : 1'b0;
                if (disturb) begin
                    bus_a.we     = 1'($urandom);
                    bus_a.addr   = 5'($urandom);
                    bus_a.datain = $urandom;
                end
            end
        end
        checkOutput("ready_latency", 32'(n), 32'(LAT_A + 1));
        if (hit && sb_a.size() > 0) begin
            gx = sb_a.pop_front();
            if (gx.is_read) checkOutput("read_data", bus_a.dataout, gx.data);
            else            checkOutput("write_dataout_hold", bus_a.dataout, gx.data);
            checkOutput("busy_in_resp", 32'(bus_a.busy), 32'd1);
            if (disturb) begin
                bus_a.req    = 1'b1;
                bus_a.we     = 1'b1;
                bus_a.addr   = 5'($urandom);
                bus_a.datain = $urandom;
            end
        end else if (sb_a.size() > 0) begin
            void'(sb_a.pop_front());
        end
        @(negedge clk);
        bus_a.req = 1'b0;
        checkOutput("ready_one_cycle", 32'(bus_a.ready), 32'd0);
        checkOutput("busy_back_idle", 32'(bus_a.busy), 32'd0);
        checkOutput("rd_cnt", 32'(bus_a.rd_cnt), 32'(rd_exp_a));
        checkOutput("wr_cnt", 32'(bus_a.wr_cnt), 32'(wr_exp_a));
        if (disturb) begin
            @(negedge clk);
            checkOutput("no_reaccept_after_resp", 32'(bus_a.busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.datain = '0;
        bus_z.req = 1'b0; bus_z.we = 1'b0; bus_z.addr = '0; bus_z.datain = '0;
        bus_c.req = 1'b0; bus_c.we = 1'b0; bus_c.addr = '0; bus_c.datain = '0;
        for (int i = 0; i < 32; i++) begin
            model_a[i] = '0;
            model_z[i] = '0;
        end
        last_read_a = '0;
        last_read_z = '0;
        rd_exp_a    = 0;
        wr_exp_a    = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(bus_a.ready), 32'd0);
        checkOutput("rst_busy", 32'(bus_a.busy), 32'd0);
        checkOutput("rst_dataout", bus_a.dataout, 32'd0);
        checkOutput("rst_rd_cnt", 32'(bus_a.rd_cnt), 32'd0);
        checkOutput("rst_wr_cnt", 32'(bus_a.wr_cnt), 32'd0);

        $display("[TB] read after reset, then write/read back-to-back");
        applyStimulus(1'b0, 5'd5, 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 5'd3, 32'h0, 1'b0);
        applyStimulus(1'b1, 5'd31, 32'hA5A5_0F0F, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0);
        applyStimulus(1'b0, 5'd31, 32'h0, 1'b0);

        $display("[TB] inputs disturbed while busy");
        applyStimulus(1'b1, 5'd9, 32'hCAFE0009, 1'b1);
        applyStimulus(1'b0, 5'd9, 32'h0, 1'b1);
        applyStimulus(1'b0, 5'd10, 32'h0, 1'b0);

        $display("[TB] LATENCY=0 with req held high");
        bus_z.req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                bus_z.we     = (i < 4);
                bus_z.addr   = 5'(i % 4);
                bus_z.datain = 32'(i + 1);
                e.is_read    = (i >= 4);
                if (i < 4) begin
                    e.data          = last_read_z;
                    model_z[i % 4]  = 32'(i + 1);
                end else begin
                    e.data      = model_z[i % 4];
                    last_read_z = model_z[i % 4];
                end
                sb_z.push_back(e);
            end else begin
                bus_z.req = 1'b0;
            end
            if (i > 0 || i == 8) begin
                checkOutput("lat0_ready_gap", 32'(bus_z.ready), 32'd0);
            end
            if (i < 8) begin
                @(negedge clk);
                checkOutput("lat0_ready_pulse", 32'(bus_z.ready), 32'd1);
                if (sb_z.size() > 0) begin
                    got = sb_z.pop_front();
                    checkOutput("lat0_dataout", bus_z.dataout, got.data);
                end
                @(negedge clk);
            end
        end
        checkOutput("lat0_rd_cnt", 32'(bus_z.rd_cnt), 32'd4);
        checkOutput("lat0_wr_cnt", 32'(bus_z.wr_cnt), 32'd4);

        $display("[TB] CNT_W=2 saturation");
        cnt_exp_c = 0;
        for (int i = 0; i < 5; i++) begin
            bus_c.req  = 1'b1;
            bus_c.we   = 1'b0;
            bus_c.addr = 5'(i);
            e.is_read  = 1'b1;
            e.data     = 32'h0;
            sb_c.push_back(e);
            cycles = 0;
            seen   = 1'b0;
            while (!seen && cycles < 20) begin
                @(negedge clk);
                bus_c.req = 1'b0;
                cycles++;
                seen = bus_c.ready;
            end
            checkOutput("sat_latency", 32'(cycles), 32'd3);
            if (seen && sb_c.size() > 0) begin
                got = sb_c.pop_front();
                checkOutput("sat_read_data", bus_c.dataout, got.data);
            end
            @(negedge clk);
            cnt_exp_c = (cnt_exp_c == 3) ? 3 : cnt_exp_c + 1;
            checkOutput("sat_rd_cnt", 32'(bus_c.rd_cnt), 32'(cnt_exp_c));
        end

        $display("[TB] reset aborts a pending write");
        bus_a.req    = 1'b1;
        bus_a.we     = 1'b1;
        bus_a.addr   = 5'd7;
        bus_a.datain = 32'h12345678;
        @(negedge clk);
        bus_a.req = 1'b0;
        checkOutput("abort_busy_before", 32'(bus_a.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy_after", 32'(bus_a.busy), 32'd0);
        checkOutput("abort_dataout_cleared", bus_a.dataout, 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("abort_no_ready", 32'(bus_a.ready), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 32; i++) model_a[i] = '0;
        last_read_a = '0;
        rd_exp_a    = 0;
        wr_exp_a    = 0;
        sb_a.delete();
        applyStimulus(1'b0, 5'd7, 32'h0, 1'b0);
        applyStimulus(1'b0, 5'd3, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
